// File: rtl/sensor_limit_monitor.sv
// Per-channel sensor sample capture with programmable inclusive min/max limits,
// N-sample debounce, sticky faults and an aggregate good flag for safety logic.
module sensor_limit_monitor #(
   parameter int unsigned N_CH     = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CH_W     = $clog2(N_CH),
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     rsp_ready_o,
   input  logic                     rsp_valid_i,
   input  logic [DATA_W-1:0]        rsp_data_i,
   input  logic                     rsp_eop_i,
   input  logic [CH_W-1:0]          rsp_ch_i,
   input  logic                     cfg_wr_i,
   input  logic [CH_W-1:0]          cfg_ch_i,
   input  logic [DATA_W-1:0]        cfg_min_i,
   input  logic [DATA_W-1:0]        cfg_max_i,
   input  logic                     cfg_en_i,
   input  logic                     clear_i,
   output logic [N_CH*DATA_W-1:0]   sample_o,
   output logic [N_CH-1:0]          fault_o,
   output logic [N_CH-1:0]          seen_o,
   output logic                     sample_done_o,
   output logic                     ch_err_o,
   output logic                     all_good_o
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

   typedef enum logic [1:0] {ST_UNSEEN, ST_OK, ST_PEND, ST_FAULT} ch_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] hi;
      logic              en;
   } ch_cfg_t;

   ch_cfg_t   [N_CH-1:0]             cfg_q;
   logic      [N_CH-1:0][DATA_W-1:0] sample_q;
   logic      [N_CH-1:0]             seen_q, fault_q, last_ok_q;
   ch_state_t                        st_q  [N_CH];
   ch_state_t                        st_n  [N_CH];
   logic      [CNT_W-1:0]            cnt_q [N_CH];
   logic      [CNT_W-1:0]            cnt_n [N_CH];
   logic      [CNT_W-1:0]            run;
   logic                             rdy_q, eval_q, done_q, ch_err_q, good_q;
   logic      [CH_W-1:0]             eval_ch_q;
   logic      [N_CH-1:0]             in_rng, eval_hit, cfg_hit, cap_hit, good_vec;
   logic      [N_CH-1:0]             fault_n, last_ok_n;
   logic                             accept, ch_bad;

   // Config writes steal the response port for their cycle.
   assign rsp_ready_o = rdy_q & ~cfg_wr_i;
   assign accept      = rsp_valid_i & rsp_ready_o & rsp_eop_i;
   assign ch_bad      = {1'b0, rsp_ch_i} >= N_CH_L;

   // Per-channel decode; out-of-range channel indices match no slot.
   always_comb begin
      in_rng   = '0;
      eval_hit = '0;
      cfg_hit  = '0;
      cap_hit  = '0;
      good_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_rng[i]   = (cfg_q[i].lo <= sample_q[i]) && (sample_q[i] <= cfg_q[i].hi);
         eval_hit[i] = eval_q && (eval_ch_q == CH_W'(i));
         cfg_hit[i]  = cfg_wr_i && (cfg_ch_i == CH_W'(i));
         cap_hit[i]  = accept && (rsp_ch_i == CH_W'(i));
         good_vec[i] = ~cfg_q[i].en | (st_q[i] == ST_OK);
      end
   end

   // Channel FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= ST_UNSEEN;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_n[i];
            cnt_q[i] <= cnt_n[i];
         end
      end
   end

   // Next state: clear first, then the evaluation, and a config write overrides both.
   always_comb begin
      run       = '0;
      fault_n   = '0;
      last_ok_n = last_ok_q;
      for (int i = 0; i < N_CH; i++) begin
         st_n[i]  = st_q[i];
         cnt_n[i] = cnt_q[i];
      end
      for (int i = 0; i < N_CH; i++) begin
         if (clear_i && (st_q[i] == ST_FAULT)) begin
            st_n[i]  = last_ok_q[i] ? ST_OK : ST_PEND;
            cnt_n[i] = '0;
         end
         if (eval_hit[i]) begin
            last_ok_n[i] = in_rng[i];
            if (st_n[i] != ST_FAULT) begin
               if (in_rng[i]) begin
                  st_n[i]  = ST_OK;
                  cnt_n[i] = '0;
               end else begin
                  run = ((st_n[i] == ST_PEND) ? cnt_n[i] : CNT_W'(0)) + CNT_W'(1);
                  if (run == CNT_W'(DEBOUNCE)) begin
                     st_n[i]  = ST_FAULT;
                     cnt_n[i] = '0;
                  end else begin
                     st_n[i]  = ST_PEND;
                     cnt_n[i] = run;
                  end
               end
            end
         end
         if (cfg_hit[i]) begin
            st_n[i]  = ST_UNSEEN;
            cnt_n[i] = '0;
         end
         fault_n[i] = (st_n[i] == ST_FAULT);
      end
   end

   // Capture, limits, evaluation pipeline and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q     <= 1'b0;
         sample_q  <= '0;
         seen_q    <= '0;
         fault_q   <= '0;
         last_ok_q <= '0;
         eval_q    <= 1'b0;
         eval_ch_q <= '0;
         done_q    <= 1'b0;
         ch_err_q  <= 1'b0;
         good_q    <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            cfg_q[i].lo <= '0;
            cfg_q[i].hi <= '1;
            cfg_q[i].en <= 1'b0;
         end
      end else begin
         rdy_q     <= 1'b1;
         fault_q   <= fault_n;
         last_ok_q <= last_ok_n;
         eval_q    <= accept & ~ch_bad;
         eval_ch_q <= rsp_ch_i;
         done_q    <= eval_q;
         ch_err_q  <= (ch_err_q & ~clear_i) | (accept & ch_bad);
         good_q    <= &good_vec;
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_hit[i]) begin
               cfg_q[i].lo <= cfg_min_i;
               cfg_q[i].hi <= cfg_max_i;
               cfg_q[i].en <= cfg_en_i;
               seen_q[i]   <= 1'b0;
            end else if (cap_hit[i]) begin
               seen_q[i]   <= 1'b1;
            end
            if (cap_hit[i]) begin
               sample_q[i] <= rsp_data_i;
            end
         end
      end
   end

   assign sample_o      = sample_q;
   assign fault_o       = fault_q;
   assign seen_o        = seen_q;
   assign sample_done_o = done_q;
   assign ch_err_o      = ch_err_q;
   assign all_good_o    = good_q;

endmodule

// File: tb/tb_sensor_limit_monitor.sv
// Scoreboard bench for sensor_limit_monitor: directed samples push expected
// results; a monitor compares them whenever sample_done_o pulses.
module tb_sensor_limit_monitor;

   localparam int unsigned N_CH     = 12;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned CH_W     = 4;
   localparam int unsigned DEBOUNCE = 3;

   logic                   clk, reset;
   logic                   rsp_ready_o, rsp_valid, rsp_eop;
   logic [DATA_W-1:0]      rsp_data;
   logic [CH_W-1:0]        rsp_ch;
   logic                   cfg_wr, cfg_en, clear;
   logic [CH_W-1:0]        cfg_ch;
   logic [DATA_W-1:0]      cfg_min, cfg_max;
   logic [N_CH*DATA_W-1:0] sample_o;
   logic [N_CH-1:0]        fault_o, seen_o;
   logic                   sample_done_o, ch_err_o, all_good_o;

   typedef struct {
      int          ch;
      logic [31:0] data;
      logic        fault;
      logic        good;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   sensor_limit_monitor #(
      .N_CH(N_CH), .DATA_W(DATA_W), .CH_W(CH_W), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk(clk), .reset(reset),
      .rsp_ready_o(rsp_ready_o), .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
      .rsp_eop_i(rsp_eop), .rsp_ch_i(rsp_ch),
      .cfg_wr_i(cfg_wr), .cfg_ch_i(cfg_ch), .cfg_min_i(cfg_min), .cfg_max_i(cfg_max),
      .cfg_en_i(cfg_en), .clear_i(clear),
      .sample_o(sample_o), .fault_o(fault_o), .seen_o(seen_o),
      .sample_done_o(sample_done_o), .ch_err_o(ch_err_o), .all_good_o(all_good_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] samp(input int ch);
      return sample_o[ch*DATA_W +: DATA_W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic cfg(input int ch, input logic [31:0] lo, input logic [31:0] hi, input logic en);
      step();
      cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_min = lo; cfg_max = hi; cfg_en = en;
      @(negedge clk);
      check("cfg_ready_low", 64'(rsp_ready_o), 0);
      step();
      cfg_wr = 1'b0;
   endtask

   // One beat; with_cfg issues a ch5 config write in the same first cycle.
   task automatic beat(input int ch, input logic [31:0] d, input logic eop, input logic with_cfg);
      logic acc;
      step();
      rsp_valid = 1'b1; rsp_eop = eop; rsp_ch = CH_W'(ch); rsp_data = d;
      if (with_cfg) begin
         cfg_wr = 1'b1; cfg_ch = CH_W'(5); cfg_min = '0; cfg_max = '0; cfg_en = 1'b0;
      end
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         if (with_cfg && k == 0) check("ready_held_by_cfg", 64'(rsp_ready_o), 0);
         acc = rsp_ready_o;
         step();
         cfg_wr = 1'b0;
      end
      if (!acc) check("beat_accept_timeout", 64'(acc), 1);
      rsp_valid = 1'b0;
      rsp_eop   = 1'b0;
   endtask

   task automatic send(input int ch, input logic [31:0] d, input logic ef, input logic eg,
                       input logic with_cfg, input logic clr_eval);
      exp_t e;
      e.ch = ch; e.data = d; e.fault = ef; e.good = eg;
      sb.push_back(e);
      beat(ch, d, 1'b1, with_cfg);
      if (clr_eval) begin
         clear = 1'b1;
         step();
         clear = 1'b0;
      end
      idle(3);
   endtask

   task automatic pulse_clear();
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Monitor: each sample_done_o pops one expectation; all_good_o is checked a cycle later.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && sample_done_o) begin
            if (sb.size() == 0) begin
               check("unexpected_sample_done", 64'(sample_done_o), 0);
            end else begin
               e = sb.pop_front();
               check($sformatf("sample_ch%0d", e.ch), 64'(samp(e.ch)), 64'(e.data));
               check($sformatf("fault_ch%0d", e.ch), 64'(fault_o[e.ch]), 64'(e.fault));
               @(negedge clk);
               check($sformatf("all_good_after_ch%0d", e.ch), 64'(all_good_o), 64'(e.good));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; rsp_valid = 1'b0; rsp_eop = 1'b0; rsp_data = '0; rsp_ch = '0;
      cfg_wr = 1'b0; cfg_ch = '0; cfg_min = '0; cfg_max = '0; cfg_en = 1'b0; clear = 1'b0;
      #12;
      check("rst_ready", 64'(rsp_ready_o), 0);
      check("rst_sample_zero", 64'(sample_o == '0), 1);
      check("rst_all_good", 64'(all_good_o), 0);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      @(negedge clk);
      check("ready_after_rst", 64'(rsp_ready_o), 1);
      check("good_no_enabled", 64'(all_good_o), 1);

      // Basic in-range capture on ch2
      cfg(2, 32'hA767, 32'hF4DB, 1'b1);
      send(2, 32'hC000, 1'b0, 1'b1, 1'b0, 1'b0);
      check("seen_ch2", 64'(seen_o[2]), 1);

      // Debounce: fault only on third consecutive out-of-range sample
      send(2, 32'h1,    1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'h1,    1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'hC000, 1'b0, 1'b1, 1'b0, 1'b0);
      send(2, 32'h1,    1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'h1,    1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'h1,    1'b1, 1'b0, 1'b0, 1'b0);
      send(2, 32'hC000, 1'b1, 1'b0, 1'b0, 1'b0);

      // Clear returns to OK since last sample was in range
      pulse_clear();
      @(negedge clk);
      check("fault_ch2_cleared", 64'(fault_o[2]), 0);
      @(negedge clk);
      check("good_after_clear", 64'(all_good_o), 1);

      // Inclusive bounds
      send(2, 32'hA767, 1'b0, 1'b1, 1'b0, 1'b0);
      send(2, 32'hF4DB, 1'b0, 1'b1, 1'b0, 1'b0);
      send(2, 32'hA766, 1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'hF4DC, 1'b0, 1'b0, 1'b0, 1'b0);
      send(2, 32'hC000, 1'b0, 1'b1, 1'b0, 1'b0);

      // Out-of-range channel index
      beat(12, 32'h55, 1'b1, 1'b0);
      idle(3);
      @(negedge clk);
      check("ch_err_set", 64'(ch_err_o), 1);
      check("ch2_sample_kept", 64'(samp(2)), 64'h0000C000);

      // Config write alongside a beat holds the beat one cycle
      send(2, 32'hB000, 1'b0, 1'b1, 1'b1, 1'b0);
      pulse_clear();
      @(negedge clk);
      check("ch_err_cleared", 64'(ch_err_o), 0);

      // Enabled but unseen channel blocks all_good
      cfg(3, 32'h0, 32'hFFFF, 1'b1);
      idle(2);
      @(negedge clk);
      check("good_ch3_unseen", 64'(all_good_o), 0);
      cfg(3, 32'h0, 32'hFFFF, 1'b0);
      idle(2);
      @(negedge clk);
      check("good_ch3_disabled", 64'(all_good_o), 1);

      // min > max on a disabled channel: faults but stays good
      cfg(4, 32'h10, 32'h5, 1'b0);
      send(4, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      send(4, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      send(4, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
      // Clear coincident with evaluation: clear to PEND, then count one
      send(4, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1);
      send(4, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      send(4, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);

      // Async reset in the middle of a packet
      beat(12, 32'h66, 1'b1, 1'b0);
      beat(2, 32'h1234, 1'b0, 1'b0);
      rsp_valid = 1'b1; rsp_ch = CH_W'(2); rsp_data = 32'h1234;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_sample", 64'(sample_o == '0), 1);
      check("midrst_fault", 64'(fault_o), 0);
      check("midrst_seen", 64'(seen_o), 0);
      check("midrst_ch_err", 64'(ch_err_o), 0);
      check("midrst_ready", 64'(rsp_ready_o), 0);
      check("midrst_good", 64'(all_good_o), 0);
      rsp_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      idle(1);
      send(2, 32'hC000, 1'b0, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 50 && sb.size() != 0; k++) step();
      check("scoreboard_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
